vga_fb_reader: RTL

Parametrised VGA scan-out engine: generates horizontal/vertical timing, fetches pixels from a synchronous framebuffer RAM with configurable read latency, and outputs pipeline-aligned `hs`/`vs`/`de`/`rgb`. It sits between the framebuffer BRAM read port and the VGA pins. Over the fixed 640x480 engine it adds:
- run-time enable;
- programmable sync polarity;
- integer pixel-replication scaling;
- a frame-start pulse for the drawing side.

---
 rtl/vga_fb_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: VGA raster timing generator that fetches pixels from a
// synchronous framebuffer RAM and presents hs/vs/de/rgb/frame_start
// aligned to the returned pixel data, with enable, sync polarity and
// integer pixel-replication scaling.
module vga_fb_reader #(
  parameter int H_VIDEO     = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIDEO     = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int RGB_W       = 12,
  parameter int ADDR_W      = 19,
  parameter int MEM_LAT     = 1,
  parameter int SCALE_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [RGB_W-1:0]  mem_data,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [RGB_W-1:0]  rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIDEO + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PIPE    = 2 + MEM_LAT;
  localparam int SRC_W   = H_VIDEO >> SCALE_SHIFT;
  localparam int SRC_H   = V_VIDEO >> SCALE_SHIFT;

  // Boundaries are one bit wider than the counters so a total that is an
  // exact power of two cannot wrap to zero.
  localparam logic [HW:0] H_LAST     = (HW+1)'(H_TOTAL - 1);
  localparam logic [HW:0] H_ACT      = (HW+1)'(H_VIDEO);
  localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_VIDEO + H_FP);
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_VIDEO + H_FP + H_SYNC);
  localparam logic [VW:0] V_LAST     = (VW+1)'(V_TOTAL - 1);
  localparam logic [VW:0] V_ACT      = (VW+1)'(V_VIDEO);
  localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_VIDEO + V_FP);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_VIDEO + V_FP + V_SYNC);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("vga_fb_reader: MEM_LAT must be within 1..4");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 2) begin : g_bad_scale
    $error("vga_fb_reader: SCALE_SHIFT must be within 0..2");
  end
  if (longint'(SRC_W) * longint'(SRC_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("vga_fb_reader: source image does not fit in ADDR_W address bits");
  end

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic              act0;
  logic              hsa0;
  logic              vsa0;
  logic              first0;
  logic [ADDR_W-1:0] addr0;
  logic [PIPE-1:0]   act_q;
  logic [PIPE-1:0]   hsa_q;
  logic [PIPE-1:0]   vsa_q;
  logic [PIPE-1:0]   first_q;

  // Raster position: h wraps every line, v advances on each h wrap; a disabled scan parks at the origin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if ({1'b0, h} == H_LAST) begin
      h <= '0;
      if ({1'b0, v} == V_LAST) begin
        v <= '0;
      end else begin
        v <= v + VW'(1);
      end
    end else begin
      h <= h + HW'(1);
    end
  end

  // Stage-0 region flags and source-image address of the current raster position.
  always_comb begin
    act0   = en && ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
    hsa0   = en && ({1'b0, h} >= H_SYNC_BEG) && ({1'b0, h} < H_SYNC_END);
    vsa0   = en && ({1'b0, v} >= V_SYNC_BEG) && ({1'b0, v} < V_SYNC_END);
    first0 = en && (h == '0) && (v == '0);
    addr0  = ADDR_W'(v >> SCALE_SHIFT) * ADDR_W'(SRC_W) + ADDR_W'(h >> SCALE_SHIFT);
  end

  // Registered RAM read request; the address is parked at zero outside active video.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_en   <= act0;
      mem_addr <= act0 ? addr0 : '0;
    end
  end

  // Delay lines carrying the timing flags alongside the RAM access so they meet the returned pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q   <= '0;
      hsa_q   <= '0;
      vsa_q   <= '0;
      first_q <= '0;
    end else begin
      act_q   <= {act_q[PIPE-2:0], act0};
      hsa_q   <= {hsa_q[PIPE-2:0], hsa0};
      vsa_q   <= {vsa_q[PIPE-2:0], vsa0};
      first_q <= {first_q[PIPE-2:0], first0};
    end
  end

  // Pixel register: captures RAM data in the cycle the matching active flag reaches the output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rgb <= '0;
    end else begin
      rgb <= act_q[PIPE-2] ? mem_data : '0;
    end
  end

  assign de          = act_q[PIPE-1];
  assign hs          = hsa_q[PIPE-1] ^ ~SYNC_POL;
  assign vs          = vsa_q[PIPE-1] ^ ~SYNC_POL;
  assign frame_start = first_q[PIPE-1];

endmodule
